adder_prefix_seq: RTL



---
 rtl/adder_seq_pkg.sv | 32 +++
 rtl/adder_prefix_seq_gp_span_stage.sv | 76 +++++++
 rtl/adder_prefix_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg
// Shared constants, FSM encoding and helpers for the iterative prefix adder.
//   W       operand width
//   STAGES  number of Kogge-Stone levels, one per clock
//   KW      width of the stage counter (must be able to count to STAGES)
//   state_t controller state encoding
//   span_mask(k) bit i set when bit i has a partner at distance 2^k
package adder_seq_pkg;

  localparam int W      = 32;
  localparam int STAGES = $clog2(W);
  localparam int KW     = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PFX  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits below the current span have no partner at distance 2^k.
  // Their group terms are already final, so the combine level leaves them alone.
  function automatic logic [W-1:0] span_mask(input logic [KW-1:0] k);
    logic [W-1:0] m;
    int           d;
    d = 1 << k;
    for (int i = 0; i < W; i++) begin
      m[i] = (i >= d);
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_prefix_seq_gp_span_stage.sv
// gp_cell
// One Kogge-Stone combine cell. It merges a high group (g_hi, p_hi) with the
// adjacent lower group (g_lo, p_lo).
//   g_hi, p_hi   in   group terms of the upper (more significant) span
//   g_lo, p_lo   in   group terms of the lower span at distance 2^k
//   g_out, p_out out  merged group terms
module gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// gp_span_stage
// A single shared prefix level. A k-indexed mux picks the partner operand at
// distance 2^k. This lets one row of gp_cells stand in for every level of the
// tree.
//   g, p          in   current group generate / propagate vectors
//   k             in   level index (span 2^k)
//   mask          in   bits that combine at this level (others hold)
//   g_nxt, p_nxt  out  group terms after this level
module gp_span_stage #(
  parameter int W  = 32,
  parameter int KW = 3
) (
  input  logic [W-1:0]  g,
  input  logic [W-1:0]  p,
  input  logic [KW-1:0] k,
  input  logic [W-1:0]  mask,
  output logic [W-1:0]  g_nxt,
  output logic [W-1:0]  p_nxt
);

  localparam int NLVL = $clog2(W);

  logic [W-1:0] g_far;
  logic [W-1:0] p_far;
  logic [W-1:0] g_cell;
  logic [W-1:0] p_cell;

  // Shifting left by 2^k puts bit i-d of the source in lane i.
  // A k outside the tree selects zero. The mask already blocks those lanes
  // in normal use.
  always_comb begin
    g_far = '0;
    p_far = '0;
    for (int s = 0; s < NLVL; s++) begin
      if (k == KW'(s)) begin
        g_far = g << (1 << s);
        p_far = p << (1 << s);
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    gp_cell u_cell (
      .g_hi  (g[i]),
      .p_hi  (p[i]),
      .g_lo  (g_far[i]),
      .p_lo  (p_far[i]),
      .g_out (g_cell[i]),
      .p_out (p_cell[i])
    );

    assign g_nxt[i] = mask[i] ? g_cell[i] : g[i];
    assign p_nxt[i] = mask[i] ? p_cell[i] : p[i];
  end

endmodule

// File: rtl/adder_prefix_seq.sv
// adder_prefix_seq
// Iterative parallel-prefix adder/subtractor. It takes one operand pair per
// transaction. The generate/propagate terms are formed on accept. One masked
// Kogge-Stone level then runs per clock for STAGES clocks. The result is held
// until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds valid and its data until that edge. Ready may
// depend on the downstream ready; it never depends on the upstream valid.
// flush blocks an accept on the same edge.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort; returns to IDLE and drops out_valid
//   in_valid / in_ready  operand handshake
//   in_a, in_b           operands (sampled only on the accept edge)
//   in_sub               1: a-b, 0: a+b
//   in_cin               carry-in for additions
//   out_valid/out_ready  result handshake
//   out_sum              W-bit result
//   out_cout             carry-out of the top bit (1 = no borrow on subtract)
//   out_ovf              two's-complement overflow
//   busy                 transaction in progress or result pending
//   dbg_state            current controller state
module adder_prefix_seq
  import adder_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy,
  output state_t       dbg_state
);

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  p0;
  logic          cin_r;

  logic          accept;
  logic [W-1:0]  b_eff;
  logic          cin_eff;
  logic [W-1:0]  g_init;
  logic [W-1:0]  p_init;
  logic [W-1:0]  mask;
  logic [W-1:0]  g_nxt;
  logic [W-1:0]  p_nxt;
  logic          last_level;
  logic [W-1:0]  carry_vec;

  // A new pair can land while the previous result is being taken.
  // This keeps back-to-back transactions free of a bubble cycle.
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Subtraction is a + ~b + 1.
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;

  // Carry-in is folded into bit 0 as an extra generate. p[0] is forced to 0
  // so that G[i] is the true carry out of bit i, including cin.
  always_comb begin
    g_init    = in_a & b_eff;
    g_init[0] = (in_a[0] & b_eff[0]) | ((in_a[0] ^ b_eff[0]) & cin_eff);
    p_init    = in_a ^ b_eff;
    p_init[0] = 1'b0;
  end

  assign mask = span_mask(k);

  gp_span_stage #(
    .W  (W),
    .KW (KW)
  ) u_span (
    .g     (g),
    .p     (p),
    .k     (k),
    .mask  (mask),
    .g_nxt (g_nxt),
    .p_nxt (p_nxt)
  );

  assign last_level = (k == KW'(STAGES - 1));

  // Carry into bit i is the group generate of bits [i-1:0]. It is taken from
  // the level being written this edge, so no extra cycle is spent.
  assign carry_vec = {g_nxt[W-2:0], cin_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      g        <= '0;
      p        <= '0;
      p0       <= '0;
      cin_r    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (flush) begin
      // Result registers keep their last value; only the handshake is cleared.
      state <= IDLE;
    end else if (accept) begin
      // accept is only possible from IDLE or from DONE while out_ready is high.
      g     <= g_init;
      p     <= p_init;
      p0    <= in_a ^ b_eff;
      cin_r <= cin_eff;
      k     <= '0;
      state <= PFX;
    end else begin
      case (state)
        PFX: begin
          g <= g_nxt;
          p <= p_nxt;
          k <= k + KW'(1);
          if (last_level) begin
            out_sum  <= p0 ^ carry_vec;
            out_cout <= g_nxt[W-1];
            // Overflow when the carry into the sign bit differs from the
            // carry out of it.
            out_ovf  <= g_nxt[W-1] ^ g_nxt[W-2];
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
